// File: rtl/column_scan_pkg.sv
// column_scan_pkg: shared state encoding and one-hot helper for the column scan decoder family
package column_scan_pkg;
  typedef enum logic {IDLE, SCAN} state_e;
  localparam int MAX_WIDTH = 8;
  localparam int MAX_N = 1 << MAX_WIDTH;
  function automatic logic [MAX_N-1:0] onehot_of(input logic [MAX_WIDTH-1:0] idx);
    onehot_of = '0;
    onehot_of[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: combinational enable + binary (en_i, bin_i) to one-hot (onehot_o), zero when disabled
module onehot_decode
  import column_scan_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int N = 1 << WIDTH
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic [N-1:0]     onehot_o
);
  assign onehot_o = en_i ? N'(onehot_of(MAX_WIDTH'(bin_i))) : '0;
endmodule

// File: rtl/column_scan_decoder.sv
// column_scan_decoder: registered position (load / forward search past block_mask) with one-hot, valid, exhausted, busy, done outputs
module column_scan_decoder
  import column_scan_pkg::*;
#(
  parameter int WIDTH = 3,
  localparam int N = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_index,
  input  logic             next,
  input  logic [N-1:0]     block_mask,
  output logic [N-1:0]     onehot,
  output logic [WIDTH-1:0] index,
  output logic             valid,
  output logic             exhausted,
  output logic             busy,
  output logic             done
);
  // one extra bit so position N is distinguishable from a wrap to 0
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(N - 1);
  localparam logic [WIDTH:0] PAST = (WIDTH+1)'(N);
  state_e           state_q, state_d;
  logic [WIDTH:0]   cand_q, cand_d, start;
  logic [WIDTH-1:0] index_q, index_d;
  logic [N-1:0]     onehot_q, onehot_d;
  logic             valid_q, valid_d, exh_q, exh_d, done_q, done_d;
  always_comb begin
    start   = valid_q ? {1'b0, index_q} + (WIDTH+1)'(1) : '0;
    state_d = state_q;
    cand_d  = cand_q;
    index_d = index_q;
    valid_d = valid_q;
    exh_d   = exh_q;
    done_d  = 1'b0;
    if (!enable) begin
    end else if (clear) begin
      state_d = IDLE;
      index_d = '0;
      valid_d = 1'b0;
      exh_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (load) begin
        index_d = load_index;
        valid_d = 1'b1;
        exh_d   = 1'b0;
      end else if (next) begin
        exh_d   = start == PAST;
        valid_d = valid_q && start != PAST;
        done_d  = start == PAST;
        cand_d  = start;
        state_d = start == PAST ? IDLE : SCAN;
      end
    end else if (!block_mask[cand_q[WIDTH-1:0]]) begin
      index_d = cand_q[WIDTH-1:0];
      valid_d = 1'b1;
      done_d  = 1'b1;
      state_d = IDLE;
    end else if (cand_q == LAST) begin
      valid_d = 1'b0;
      exh_d   = 1'b1;
      done_d  = 1'b1;
      state_d = IDLE;
    end else begin
      cand_d = cand_q + (WIDTH+1)'(1);
    end
  end
  // one-hot is registered from the next-state position so it always agrees with index/valid
  onehot_decode #(.WIDTH(WIDTH)) u_dec (
    .en_i     (valid_d),
    .bin_i    (index_d),
    .onehot_o (onehot_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      index_q  <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      exh_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      index_q  <= index_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      exh_q    <= exh_d;
      done_q   <= done_d;
    end
  end
  assign onehot    = onehot_q;
  assign index     = index_q;
  assign valid     = valid_q;
  assign exhausted = exh_q;
  assign busy      = state_q == SCAN;
  assign done      = done_q;
endmodule

// File: tb/tb_column_scan_decoder.sv
// tb_column_scan_decoder: directed self-checking bench for column_scan_decoder (WIDTH=3)
module tb_column_scan_decoder;
  logic       clk = 1'b0;
  logic       rst, enable, clear, load, next;
  logic [2:0] load_index;
  logic [7:0] block_mask;
  logic [7:0] onehot;
  logic [2:0] index;
  logic       valid, exhausted, busy, done;
  logic [14:0] obs, e;
  int checks = 0;
  int errors = 0;
  column_scan_decoder #(.WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_index (load_index),
    .next       (next),
    .block_mask (block_mask),
    .onehot     (onehot),
    .index      (index),
    .valid      (valid),
    .exhausted  (exhausted),
    .busy       (busy),
    .done       (done)
  );
  always #5 clk = ~clk;
  // observed vector: {onehot, index, valid, exhausted, busy, done}
  assign obs = {onehot, index, valid, exhausted, busy, done};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1; load = 1'b1; next = 1'b1; load_index = 3'd5;
    tick; tick;
    e = {8'h00, 3'd0, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL reset got=%h want=%h", obs, e); end
    rst = 1'b0; load = 1'b0; next = 1'b0;
    tick;
    checks++; if (obs !== e) begin errors++; $display("FAIL reset_idle got=%h want=%h", obs, e); end
  endtask
  task automatic test_load;
    load = 1'b1; load_index = 3'd5;
    tick; load = 1'b0;
    e = {8'h20, 3'd5, 4'b1000};
    checks++; if (obs !== e) begin errors++; $display("FAIL load5 got=%h want=%h", obs, e); end
    load = 1'b1; next = 1'b1; load_index = 3'd2;
    tick; load = 1'b0; next = 1'b0;
    e = {8'h04, 3'd2, 4'b1000};
    checks++; if (obs !== e) begin errors++; $display("FAIL load_over_next got=%h want=%h", obs, e); end
  endtask
  task automatic test_scan;
    clear = 1'b1; tick; clear = 1'b0;
    e = {8'h00, 3'd0, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL clear got=%h want=%h", obs, e); end
    block_mask = 8'b0000_0111; next = 1'b1;
    tick; next = 1'b0;
    e = {8'h00, 3'd0, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs !== e) begin errors++; $display("FAIL scan_busy%0d got=%h want=%h", i, obs, e); end
      if (i < 3) tick;
    end
    tick;
    e = {8'h08, 3'd3, 4'b1001};
    checks++; if (obs !== e) begin errors++; $display("FAIL scan_found got=%h want=%h", obs, e); end
    tick;
    e = {8'h08, 3'd3, 4'b1000};
    checks++; if (obs !== e) begin errors++; $display("FAIL scan_done_pulse got=%h want=%h", obs, e); end
  endtask
  task automatic test_exhaust;
    load = 1'b1; load_index = 3'd6; tick; load = 1'b0;
    block_mask = 8'b1000_0000; next = 1'b1;
    tick; next = 1'b0;
    e = {8'h40, 3'd6, 4'b1010};
    checks++; if (obs !== e) begin errors++; $display("FAIL exh_scan got=%h want=%h", obs, e); end
    tick;
    e = {8'h00, 3'd6, 4'b0101};
    checks++; if (obs !== e) begin errors++; $display("FAIL exh_done got=%h want=%h", obs, e); end
    block_mask = 8'h00; next = 1'b1;
    tick; next = 1'b0;
    e = {8'h00, 3'd6, 4'b0010};
    checks++; if (obs !== e) begin errors++; $display("FAIL restart_scan got=%h want=%h", obs, e); end
    tick;
    e = {8'h01, 3'd0, 4'b1001};
    checks++; if (obs !== e) begin errors++; $display("FAIL restart_found got=%h want=%h", obs, e); end
  endtask
  task automatic test_load_last;
    load = 1'b1; load_index = 3'd7; tick; load = 1'b0;
    e = {8'h80, 3'd7, 4'b1000};
    checks++; if (obs !== e) begin errors++; $display("FAIL load7 got=%h want=%h", obs, e); end
    next = 1'b1; tick; next = 1'b0;
    e = {8'h00, 3'd7, 4'b0101};
    checks++; if (obs !== e) begin errors++; $display("FAIL next_past_end got=%h want=%h", obs, e); end
    tick;
    e = {8'h00, 3'd7, 4'b0100};
    checks++; if (obs !== e) begin errors++; $display("FAIL past_end_idle got=%h want=%h", obs, e); end
  endtask
  task automatic test_freeze;
    block_mask = 8'b0111_1111;
    load = 1'b1; load_index = 3'd0; tick; load = 1'b0;
    next = 1'b1; tick; next = 1'b0;
    tick;
    e = {8'h01, 3'd0, 4'b1010};
    checks++; if (obs !== e) begin errors++; $display("FAIL freeze_pre got=%h want=%h", obs, e); end
    enable = 1'b0; clear = 1'b1; load = 1'b1; next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (obs !== e) begin errors++; $display("FAIL frozen%0d got=%h want=%h", i, obs, e); end
    end
    enable = 1'b1; clear = 1'b0; load = 1'b0; next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (obs !== e) begin errors++; $display("FAIL resume%0d got=%h want=%h", i, obs, e); end
    end
    tick;
    e = {8'h80, 3'd7, 4'b1001};
    checks++; if (obs !== e) begin errors++; $display("FAIL resume_found got=%h want=%h", obs, e); end
    enable = 1'b0; tick; enable = 1'b1;
    e = {8'h80, 3'd7, 4'b1000};
    checks++; if (obs !== e) begin errors++; $display("FAIL disable_kills_done got=%h want=%h", obs, e); end
  endtask
  task automatic test_reset_mid;
    block_mask = 8'hFF;
    load = 1'b1; load_index = 3'd1; tick; load = 1'b0;
    next = 1'b1; tick; next = 1'b0;
    tick;
    e = {8'h02, 3'd1, 4'b1010};
    checks++; if (obs !== e) begin errors++; $display("FAIL mid_pre got=%h want=%h", obs, e); end
    rst = 1'b1; tick; rst = 1'b0;
    e = {8'h00, 3'd0, 4'b0000};
    checks++; if (obs !== e) begin errors++; $display("FAIL mid_reset got=%h want=%h", obs, e); end
    tick; tick;
    checks++; if (obs !== e) begin errors++; $display("FAIL mid_reset_idle got=%h want=%h", obs, e); end
  endtask
  initial begin
    rst = 1'b0; enable = 1'b1; clear = 1'b0; load = 1'b0; next = 1'b0;
    load_index = 3'd0; block_mask = 8'h00;
    #1;
    test_reset;
    test_load;
    test_scan;
    test_exhaust;
    test_load_last;
    test_freeze;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
